// File: rtl/shot_clock_pkg.sv
// Shared types and width helpers for the BCD shot-clock timer.
package shot_clock_pkg;

  typedef enum logic [1:0] {
    LOADED  = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // True when every one of the low `digits` nibbles is a decimal digit.
  function automatic logic bcd_ok(input logic [31:0] v, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < digits && v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // True when the value has no bits above the low `digits` nibbles.
  function automatic logic bcd_fits(input logic [31:0] v, input int digits);
    logic [63:0] wide;
    wide = {32'd0, v};
    return (wide >> (4 * digits)) == 64'd0;
  endfunction

endpackage

// File: rtl/shot_clock_bcd_digit_dec.sv
// One BCD digit of the decrement chain: 0 with borrow-in wraps to 9 and passes the borrow on.
module bcd_digit_dec
  import shot_clock_pkg::*;
(
  input  bcd_t din,
  input  logic bin,
  output bcd_t dout,
  output logic bout
);

  always_comb begin
    dout = din;
    bout = 1'b0;
    if (bin) begin
      if (din == 4'd0) begin
        dout = 4'd9;
        bout = 1'b1;
      end else begin
        dout = din - 4'd1;
      end
    end
  end

endmodule

// File: rtl/shot_clock_bcd.sv
// Multi-digit BCD countdown with prescaler, full/short reload and stretched alarm.
// All outputs come straight from registers clocked by cp.
module shot_clock_bcd
  import shot_clock_pkg::*;
#(
  parameter int unsigned DIGITS       = 2,
  parameter logic [31:0] PRESET       = 32'h24,
  parameter logic [31:0] SHORT_PRESET = 32'h14,
  parameter int unsigned TICK_DIV     = 1,
  parameter int unsigned ALARM_CYCLES = 4
) (
  input  logic                  cp,
  input  logic                  rest,
  input  logic                  run,
  input  logic                  load_full,
  input  logic                  load_short,
  output logic [4*DIGITS-1:0]   timer,
  output logic                  expired,
  output logic                  alarm,
  output logic [1:0]            state
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = cnt_w(TICK_DIV);
  localparam int AW = cnt_w(ALARM_CYCLES);

  localparam logic [W-1:0]  PRESET_V = PRESET[W-1:0];
  localparam logic [W-1:0]  SHORT_V  = SHORT_PRESET[W-1:0];
  localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALM_LAST = AW'(ALARM_CYCLES - 1);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("shot_clock_bcd: DIGITS must be 1..8");
  end
  if (!bcd_ok(PRESET, DIGITS) || !bcd_fits(PRESET, DIGITS) || PRESET == 32'd0) begin : g_bad_preset
    $error("shot_clock_bcd: PRESET must be a non-zero BCD value of DIGITS digits");
  end
  if (!bcd_ok(SHORT_PRESET, DIGITS) || !bcd_fits(SHORT_PRESET, DIGITS) || SHORT_PRESET == 32'd0) begin : g_bad_short
    $error("shot_clock_bcd: SHORT_PRESET must be a non-zero BCD value of DIGITS digits");
  end
  if (SHORT_PRESET > PRESET) begin : g_bad_order
    $error("shot_clock_bcd: SHORT_PRESET must not exceed PRESET");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("shot_clock_bcd: TICK_DIV must be at least 1");
  end
  if (ALARM_CYCLES < 1) begin : g_bad_alarm
    $error("shot_clock_bcd: ALARM_CYCLES must be at least 1");
  end

  logic [W-1:0]  timer_q;
  logic [W-1:0]  timer_dec;
  logic [PW-1:0] psc;
  logic [AW-1:0] acnt;
  logic          alarm_q;
  logic          expired_q;
  state_t        st;
  logic [DIGITS:0] borrow;
  logic          en;
  logic          tick;

  // Borrow enters digit 0; the ripple stops at the first non-zero digit.
  assign borrow[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    bcd_digit_dec u_dig (
      .din  (timer_q[4*i +: 4]),
      .bin  (borrow[i]),
      .dout (timer_dec[4*i +: 4]),
      .bout (borrow[i+1])
    );
  end

  assign en   = run && (timer_q != '0);
  assign tick = (psc == PSC_LAST);

  always_ff @(posedge cp) begin
    if (rest || load_full) begin
      timer_q   <= PRESET_V;
      psc       <= '0;
      acnt      <= '0;
      alarm_q   <= 1'b0;
      expired_q <= 1'b0;
      st        <= LOADED;
    end else if (load_short) begin
      if (timer_q < SHORT_V) timer_q <= SHORT_V;
      psc       <= '0;
      acnt      <= '0;
      alarm_q   <= 1'b0;
      expired_q <= 1'b0;
      st        <= LOADED;
    end else begin
      if (alarm_q) begin
        if (acnt == '0) alarm_q <= 1'b0;
        else            acnt    <= acnt - 1'b1;
      end
      if (en) begin
        if (tick) begin
          psc     <= '0;
          timer_q <= timer_dec;
          // Counting only happens while non-zero, so this fires once per expiry.
          if (timer_dec == '0) begin
            expired_q <= 1'b1;
            alarm_q   <= 1'b1;
            acnt      <= ALM_LAST;
            st        <= EXPIRED;
          end else begin
            st <= RUNNING;
          end
        end else begin
          psc <= psc + 1'b1;
          st  <= RUNNING;
        end
      end else if (st == RUNNING && !run) begin
        st <= PAUSED;
      end
    end
  end

  assign timer   = timer_q;
  assign expired = expired_q;
  assign alarm   = alarm_q;
  assign state   = st;

endmodule

// File: tb/tb_shot_clock_bcd.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_shot_clock_bcd;
  import shot_clock_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rest_v = 3'b111;
  logic [2:0] run_v  = 3'b000;
  logic [2:0] lf_v   = 3'b000;
  logic [2:0] ls_v   = 3'b000;

  logic [7:0]  t0, t2;
  logic [11:0] t1;
  logic [2:0]  exp_v, alm_v;
  logic [1:0]  s0, s1, s2;

  shot_clock_bcd u_d0 (
    .cp(clk), .rest(rest_v[0]), .run(run_v[0]), .load_full(lf_v[0]), .load_short(ls_v[0]),
    .timer(t0), .expired(exp_v[0]), .alarm(alm_v[0]), .state(s0));

  shot_clock_bcd #(.DIGITS(3), .PRESET(32'h100)) u_d1 (
    .cp(clk), .rest(rest_v[1]), .run(run_v[1]), .load_full(lf_v[1]), .load_short(ls_v[1]),
    .timer(t1), .expired(exp_v[1]), .alarm(alm_v[1]), .state(s1));

  shot_clock_bcd #(.TICK_DIV(3)) u_d2 (
    .cp(clk), .rest(rest_v[2]), .run(run_v[2]), .load_full(lf_v[2]), .load_short(ls_v[2]),
    .timer(t2), .expired(exp_v[2]), .alarm(alm_v[2]), .state(s2));

  typedef struct {
    int          cyc;
    int          dut;
    string       name;
    logic [11:0] t;
    logic        e;
    logic        a;
    logic [1:0]  s;
  } exp_t;

  exp_t q[$];
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [11:0] bcd(input int n);
    return 12'((n / 100) * 256 + ((n / 10) % 10) * 16 + (n % 10));
  endfunction

  task automatic expect1(input string nm, input int d, input logic [11:0] t,
                         input logic e, input logic a, input logic [1:0] s);
    exp_t x;
    x.cyc = cyc + 1; x.dut = d; x.name = nm; x.t = t; x.e = e; x.a = a; x.s = s;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    logic [11:0] at;
    logic ae, aa;
    logic [1:0] as;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      x = q.pop_front();
      case (x.dut)
        0:       begin at = {4'h0, t0}; as = s0; end
        1:       begin at = t1;         as = s1; end
        default: begin at = {4'h0, t2}; as = s2; end
      endcase
      ae = exp_v[x.dut];
      aa = alm_v[x.dut];
      total++;
      if (x.cyc != cyc || at !== x.t || ae !== x.e || aa !== x.a || as !== x.s) begin
        bad++;
        $display("FAIL %s dut%0d cyc%0d: got t=%h exp=%b alm=%b st=%0d, want t=%h exp=%b alm=%b st=%0d",
                 x.name, x.dut, cyc, at, ae, aa, as, x.t, x.e, x.a, x.s);
      end
    end
  end

  initial begin
    // Default instance: full countdown 24..00 with alarm stretch.
    expect1("reset", 0, 12'h024, 0, 0, LOADED);
    step();
    rest_v = 3'b000;
    run_v[0] = 1'b1;
    for (int n = 23; n >= 0; n--) begin
      expect1("count", 0, bcd(n), n == 0, n == 0, (n == 0) ? EXPIRED : RUNNING);
      step();
    end
    for (int k = 1; k <= 5; k++) begin
      expect1("alarm_hold", 0, 12'h000, 1, k < 4, EXPIRED);
      step();
    end

    // Load on the final tick edge wins, no alarm.
    run_v[0] = 1'b0; lf_v[0] = 1'b1;
    expect1("load_full_exp", 0, 12'h024, 0, 0, LOADED);
    step();
    lf_v[0] = 1'b0; run_v[0] = 1'b1;
    for (int n = 23; n >= 1; n--) begin
      expect1("count2", 0, bcd(n), 0, 0, RUNNING);
      step();
    end
    lf_v[0] = 1'b1;
    expect1("load_on_last_tick", 0, 12'h024, 0, 0, LOADED);
    step();
    lf_v[0] = 1'b0; run_v[0] = 1'b0;
    expect1("no_alarm_after", 0, 12'h024, 0, 0, LOADED);
    step();

    // Load during the second alarm cycle drops alarm at once.
    run_v[0] = 1'b1;
    for (int n = 23; n >= 0; n--) begin
      expect1("count3", 0, bcd(n), n == 0, n == 0, (n == 0) ? EXPIRED : RUNNING);
      step();
    end
    expect1("alarm_cyc2", 0, 12'h000, 1, 1, EXPIRED);
    step();
    lf_v[0] = 1'b1;
    expect1("load_in_alarm", 0, 12'h024, 0, 0, LOADED);
    step();
    lf_v[0] = 1'b0;

    // Pause at 09, then short reload raises to 14.
    for (int n = 23; n >= 9; n--) begin
      expect1("count4", 0, bcd(n), 0, 0, RUNNING);
      step();
    end
    run_v[0] = 1'b0;
    expect1("pause", 0, 12'h009, 0, 0, PAUSED);
    step();
    ls_v[0] = 1'b1;
    expect1("short_raise", 0, 12'h014, 0, 0, LOADED);
    step();
    ls_v[0] = 1'b0; lf_v[0] = 1'b1;
    expect1("reload", 0, 12'h024, 0, 0, LOADED);
    step();
    lf_v[0] = 1'b0; run_v[0] = 1'b1;
    for (int n = 23; n >= 20; n--) begin
      expect1("count5", 0, bcd(n), 0, 0, RUNNING);
      step();
    end
    run_v[0] = 1'b0; ls_v[0] = 1'b1;
    expect1("short_keep", 0, 12'h020, 0, 0, LOADED);
    step();
    ls_v[0] = 1'b0;

    // Three-digit instance: borrow across two digits.
    rest_v[1] = 1'b1;
    expect1("reset3", 1, 12'h100, 0, 0, LOADED);
    step();
    rest_v[1] = 1'b0; run_v[1] = 1'b1;
    expect1("borrow2", 1, 12'h099, 0, 0, RUNNING);
    step();
    expect1("dec3", 1, 12'h098, 0, 0, RUNNING);
    step();
    run_v[1] = 1'b0;
    expect1("pause3", 1, 12'h098, 0, 0, PAUSED);
    step();

    // Prescaled instance: fractional tick survives a pause.
    rest_v[2] = 1'b1;
    expect1("reset_div", 2, 12'h024, 0, 0, LOADED);
    step();
    rest_v[2] = 1'b0; run_v[2] = 1'b1;
    expect1("div_e1", 2, 12'h024, 0, 0, RUNNING); step();
    expect1("div_e2", 2, 12'h024, 0, 0, RUNNING); step();
    expect1("div_e3", 2, 12'h023, 0, 0, RUNNING); step();
    expect1("div_e4", 2, 12'h023, 0, 0, RUNNING); step();
    run_v[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect1("div_pause", 2, 12'h023, 0, 0, PAUSED);
      step();
    end
    run_v[2] = 1'b1;
    expect1("div_e5", 2, 12'h023, 0, 0, RUNNING); step();
    expect1("div_e6", 2, 12'h022, 0, 0, RUNNING); step();
    expect1("div_e7", 2, 12'h022, 0, 0, RUNNING); step();
    // Reset beats load_short and clears the half-done prescale.
    rest_v[2] = 1'b1; ls_v[2] = 1'b1;
    expect1("rest_and_short", 2, 12'h024, 0, 0, LOADED); step();
    rest_v[2] = 1'b0; ls_v[2] = 1'b0;
    expect1("psc_clr1", 2, 12'h024, 0, 0, RUNNING); step();
    expect1("psc_clr2", 2, 12'h024, 0, 0, RUNNING); step();
    expect1("psc_clr3", 2, 12'h023, 0, 0, RUNNING); step();

    step();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
